// File: rtl/ccip_outstanding_tracker.sv
// CCI-P outstanding cacheline tracker: per-channel credit counters, drain handshake, sticky error flags.
// Optional read-response watchdog enabled by defining ASE_TRACKER_WATCHDOG_EN.
module ccip_outstanding_tracker #(
  parameter int unsigned MAX_OUTSTANDING = 256,
  parameter int unsigned WD_CYCLES       = 4096,
  localparam int unsigned CNT_W          = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic             clk,
  input  logic             SoftReset_n,
  input  logic             c0_req_valid,
  input  logic [1:0]       c0_req_cllen,
  input  logic             c1_req_valid,
  input  logic             c0_rsp_valid,
  input  logic             c1_rsp_valid,
  input  logic             c1_rsp_format,
  input  logic [1:0]       c1_rsp_clnum,
  input  logic             drain_req,
  output logic [CNT_W-1:0] rd_outstanding,
  output logic [CNT_W-1:0] wr_outstanding,
  output logic             drain_ack,
  output logic [5:0]       err_flags
);

  localparam int unsigned NW = CNT_W + 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       rd_issue_c, wr_ret_c;
  logic [NW-1:0]    rd_sum_c, wr_sum_c, rd_diff_c, wr_diff_c;
  logic [CNT_W-1:0] rd_nxt_c, wr_nxt_c;
  logic             rd_udf_c, wr_udf_c, rd_ovf_c, wr_ovf_c, cllen_err_c;
  logic             cnt_zero_c, wd_hit_c;

  // Line counts contributed by this cycle's events; illegal cllen still consumes one line
  always_comb begin
    rd_issue_c  = 3'd0;
    cllen_err_c = 1'b0;
    if (c0_req_valid) begin
      case (c0_req_cllen)
        2'b00:   rd_issue_c = 3'd1;
        2'b01:   rd_issue_c = 3'd2;
        2'b11:   rd_issue_c = 3'd4;
        default: begin
          rd_issue_c  = 3'd1;
          cllen_err_c = 1'b1;
        end
      endcase
    end
    wr_ret_c = 3'd0;
    if (c1_rsp_valid)
      wr_ret_c = c1_rsp_format ? (3'(c1_rsp_clnum) + 3'd1) : 3'd1;
  end

  // Net all same-cycle events in one update, saturating at both ends
  always_comb begin
    rd_sum_c  = NW'(rd_outstanding) + NW'(rd_issue_c);
    wr_sum_c  = NW'(wr_outstanding) + NW'(c1_req_valid);
    rd_udf_c  = NW'(c0_rsp_valid) > rd_sum_c;
    wr_udf_c  = NW'(wr_ret_c) > wr_sum_c;
    rd_diff_c = rd_sum_c - NW'(c0_rsp_valid);
    wr_diff_c = wr_sum_c - NW'(wr_ret_c);
    rd_ovf_c  = !rd_udf_c && (rd_diff_c > NW'(MAX_OUTSTANDING));
    wr_ovf_c  = !wr_udf_c && (wr_diff_c > NW'(MAX_OUTSTANDING));
    rd_nxt_c  = CNT_W'(rd_diff_c);
    wr_nxt_c  = CNT_W'(wr_diff_c);
    if (rd_udf_c) rd_nxt_c = '0;
    if (rd_ovf_c) rd_nxt_c = CNT_W'(MAX_OUTSTANDING);
    if (wr_udf_c) wr_nxt_c = '0;
    if (wr_ovf_c) wr_nxt_c = CNT_W'(MAX_OUTSTANDING);
    cnt_zero_c = (rd_nxt_c == '0) && (wr_nxt_c == '0);
  end

  // Drain FSM, steered by the post-update counts
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain_req)        state_nxt = cnt_zero_c ? DONE : DRAIN;
        else if (!cnt_zero_c) state_nxt = BUSY;
      end
      BUSY: begin
        if (drain_req)        state_nxt = DRAIN;
        else if (cnt_zero_c)  state_nxt = IDLE;
      end
      DRAIN: begin
        if (!drain_req)       state_nxt = BUSY;
        else if (cnt_zero_c)  state_nxt = DONE;
      end
      DONE: begin
        if (!drain_req)       state_nxt = cnt_zero_c ? IDLE : BUSY;
        else if (!cnt_zero_c) state_nxt = DRAIN;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ASE_TRACKER_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;

  // Cycles since the last read response while reads are pending
  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n)                             wd_cnt <= '0;
    else if (rd_outstanding == '0 || c0_rsp_valid) wd_cnt <= '0;
    else if (wd_cnt != WD_W'(WD_CYCLES))           wd_cnt <= wd_cnt + WD_W'(1);
  end

  assign wd_hit_c = (rd_outstanding != '0) && !c0_rsp_valid &&
                    (wd_cnt == WD_W'(WD_CYCLES - 1));
`else
  logic unused_wd_cfg;
  assign unused_wd_cfg = ^32'(WD_CYCLES);
  assign wd_hit_c      = 1'b0;
`endif

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state          <= IDLE;
      rd_outstanding <= '0;
      wr_outstanding <= '0;
      drain_ack      <= 1'b0;
      err_flags      <= '0;
    end else begin
      state          <= state_nxt;
      rd_outstanding <= rd_nxt_c;
      wr_outstanding <= wr_nxt_c;
      drain_ack      <= (state_nxt == DONE);
      err_flags      <= err_flags | {wd_hit_c, cllen_err_c, wr_ovf_c, rd_ovf_c, wr_udf_c, rd_udf_c};
    end
  end

endmodule

// File: tb/tb_ccip_outstanding_tracker.sv
// Directed self-checking bench for ccip_outstanding_tracker (MAX_OUTSTANDING=8, WD_CYCLES=16).
module tb_ccip_outstanding_tracker;

  localparam int unsigned MAX   = 8;
  localparam int unsigned WD    = 16;
  localparam int unsigned CNT_W = $clog2(MAX) + 1;
  localparam int unsigned S_IDLE = 0, S_BUSY = 1, S_DRAIN = 2, S_DONE = 3;
`ifdef ASE_TRACKER_WATCHDOG_EN
  localparam logic WD_EN = 1'b1;
`else
  localparam logic WD_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             SoftReset_n;
  logic             c0_req_valid, c1_req_valid, c0_rsp_valid, c1_rsp_valid, c1_rsp_format;
  logic [1:0]       c0_req_cllen, c1_rsp_clnum;
  logic             drain_req;
  logic [CNT_W-1:0] rd_outstanding, wr_outstanding;
  logic             drain_ack;
  logic [5:0]       err_flags;

  int checks = 0;
  int errors = 0;

  ccip_outstanding_tracker #(.MAX_OUTSTANDING(MAX), .WD_CYCLES(WD)) dut (
    .clk(clk), .SoftReset_n(SoftReset_n),
    .c0_req_valid(c0_req_valid), .c0_req_cllen(c0_req_cllen),
    .c1_req_valid(c1_req_valid), .c0_rsp_valid(c0_rsp_valid),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_format(c1_rsp_format),
    .c1_rsp_clnum(c1_rsp_clnum), .drain_req(drain_req),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .drain_ack(drain_ack), .err_flags(err_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given pulses, then outputs are sampled 1ns after the edge
  task automatic step(input logic rqv, input logic [1:0] cl, input logic wqv,
                      input logic rsv, input logic wsv, input logic fmt, input logic [1:0] num);
    c0_req_valid = rqv; c0_req_cllen = cl; c1_req_valid = wqv;
    c0_rsp_valid = rsv; c1_rsp_valid = wsv; c1_rsp_format = fmt; c1_rsp_clnum = num;
    @(posedge clk); #1;
    c0_req_valid = 1'b0; c0_req_cllen = 2'b00; c1_req_valid = 1'b0;
    c0_rsp_valid = 1'b0; c1_rsp_valid = 1'b0; c1_rsp_format = 1'b0; c1_rsp_clnum = 2'b00;
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic rd_req(input logic [1:0] cl);
    step(1'b1, cl, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic rd_rsp();
    step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    SoftReset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    SoftReset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    SoftReset_n = 1'b0; drain_req = 1'b0;
    c0_req_valid = 1'b0; c0_req_cllen = 2'b00; c1_req_valid = 1'b0;
    c0_rsp_valid = 1'b0; c1_rsp_valid = 1'b0; c1_rsp_format = 1'b0; c1_rsp_clnum = 2'b00;
    #12;
    check("rst_rd", 32'(rd_outstanding), 0);
    check("rst_wr", 32'(wr_outstanding), 0);
    check("rst_flags", 32'(err_flags), 0);
    check("rst_ack", 32'(drain_ack), 0);
    do_reset();

    // 4-line read then four response beats
    rd_req(2'b11);
    check("rd4_cnt", 32'(rd_outstanding), 4);
    check("rd4_busy", 32'(dut.state), S_BUSY);
    for (int i = 3; i >= 0; i--) begin
      rd_rsp();
      check("rd4_beat", 32'(rd_outstanding), 32'(i));
    end
    check("rd4_idle", 32'(dut.state), S_IDLE);
    check("rd4_flags", 32'(err_flags), 0);

    // 4 writes retired by one packed response
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
      check("wr_inc", 32'(wr_outstanding), 32'(i));
    end
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11);
    check("wr_packed", 32'(wr_outstanding), 0);

    // Same-cycle 2-line request and one response with count 1
    rd_req(2'b00);
    check("net_pre", 32'(rd_outstanding), 1);
    step(1'b1, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
    check("net_same", 32'(rd_outstanding), 2);
    rd_rsp(); rd_rsp();
    check("net_drain", 32'(rd_outstanding), 0);
    check("net_flags", 32'(err_flags), 0);

    // Write underflow, then illegal cllen
    step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    check("wr_udf_cnt", 32'(wr_outstanding), 0);
    check("wr_udf_flag", 32'(err_flags), 32'h02);
    rd_req(2'b10);
    check("ill_cnt", 32'(rd_outstanding), 1);
    check("ill_flag", 32'(err_flags), 32'h12);
    rd_rsp();

    // Read overflow saturates at MAX
    rd_req(2'b11); rd_req(2'b11);
    check("ovf_full", 32'(rd_outstanding), 8);
    check("ovf_noflag", 32'(err_flags), 32'h12);
    rd_req(2'b00);
    check("ovf_sat", 32'(rd_outstanding), 8);
    check("ovf_flag", 32'(err_flags), 32'h16);

    // Reset mid-traffic clears everything; a late response underflows
    do_reset();
    check("mid_rst_rd", 32'(rd_outstanding), 0);
    check("mid_rst_flags", 32'(err_flags), 0);
    rd_rsp();
    check("late_rsp_cnt", 32'(rd_outstanding), 0);
    check("late_rsp_flag", 32'(err_flags), 32'h01);
    do_reset();

    // Drain handshake with 3 reads pending
    rd_req(2'b01); rd_req(2'b00);
    check("drn_cnt", 32'(rd_outstanding), 3);
    drain_req = 1'b1;
    idle();
    check("drn_state", 32'(dut.state), S_DRAIN);
    check("drn_ack0", 32'(drain_ack), 0);
    rd_rsp(); rd_rsp();
    check("drn_ack1", 32'(drain_ack), 0);
    rd_rsp();
    check("drn_done", 32'(dut.state), S_DONE);
    check("drn_ack", 32'(drain_ack), 1);
    drain_req = 1'b0;
    idle();
    check("drn_idle", 32'(dut.state), S_IDLE);
    check("drn_ack_off", 32'(drain_ack), 0);

    // Drain aborted returns to BUSY
    rd_req(2'b00);
    drain_req = 1'b1;
    idle();
    check("abort_drain", 32'(dut.state), S_DRAIN);
    drain_req = 1'b0;
    idle();
    check("abort_busy", 32'(dut.state), S_BUSY);
    rd_rsp();
    check("abort_idle", 32'(dut.state), S_IDLE);
    check("drn_flags", 32'(err_flags), 0);

    // Watchdog: one read, no response
    rd_req(2'b00);
    for (int i = 0; i < 15; i++) idle();
    check("wd_15", 32'(err_flags[5]), 0);
    idle();
    check("wd_16", 32'(err_flags[5]), 32'(WD_EN));
    for (int i = 0; i < 8; i++) idle();
    check("wd_sticky", 32'(err_flags[5]), 32'(WD_EN));
    check("wd_rd", 32'(rd_outstanding), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
